mips_id_stage: RTL

//  Instruction-decode stage directly downstream of the fetch unit. Holds the IF/ID register,

---
 rtl/mips_id_stage_if.sv | 36 +++
 rtl/mips_id_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/mips_id_stage_if.sv
// mips_id_stage_if: fetch <-> decode/execute bundle for the MIPS ID stage
interface mips_id_stage_if;
  logic [31:0] if_ir;
  logic        flush;
  logic        stall;
  logic        if_branch;
  logic        if_jump;
  logic [15:0] if_imm16;
  logic [25:0] if_imm26;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        ex_alusrc;
  logic        ex_regdst;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [31:0] ex_imm32;
  logic [5:0]  ex_funct;
  logic        illegal;
  modport master (
    output if_ir, flush,
    input  stall, if_branch, if_jump, if_imm16, if_imm26, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst, ex_aluop, ex_rs, ex_rt, ex_rd,
           ex_imm32, ex_funct, illegal
  );
  modport slave (
    input  if_ir, flush,
    output stall, if_branch, if_jump, if_imm16, if_imm26, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst, ex_aluop, ex_rs, ex_rt, ex_rd,
           ex_imm32, ex_funct, illegal
  );
endinterface

// File: rtl/mips_id_stage.sv
// mips_id_stage: IF/ID register, MIPS decode, load-use hazard detect and ID/EX register
module mips_id_stage #(
  parameter bit          HAZARD_EN = 1'b1,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input logic          clk,
  input logic          reset,
  mips_id_stage_if.slave s
);
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        regdst;
    logic [1:0]  aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm32;
    logic [5:0]  funct;
    logic        illegal;
  } ex_t;
  logic [31:0] r_ir;
  logic        r_valid;
  ex_t         r_ex;
  ex_t         w_dec;
  logic [5:0]  w_op;
  logic [15:0] w_imm;
  logic        w_r, w_lw, w_sw, w_beq, w_j, w_addi, w_ori, w_lui, w_known;
  logic        w_stall, w_bubble;
  assign w_op    = r_ir[31:26];
  assign w_imm   = r_ir[15:0];
  assign w_r     = w_op == 6'b000000;
  assign w_lw    = w_op == 6'b100011;
  assign w_sw    = w_op == 6'b101011;
  assign w_beq   = w_op == 6'b000100;
  assign w_j     = w_op == 6'b000010;
  assign w_addi  = w_op == 6'b001000;
  assign w_ori   = w_op == 6'b001101;
  assign w_lui   = w_op == 6'b001111;
  assign w_known = w_r | w_lw | w_sw | w_beq | w_j | w_addi | w_ori | w_lui;
  // rt only matters as a source for ops that actually read it
  assign w_stall = HAZARD_EN && r_ex.valid && r_ex.memread && r_ex.rt != 5'd0 && r_valid &&
                   (r_ex.rt == r_ir[25:21] || (r_ex.rt == r_ir[20:16] && (w_r || w_sw || w_beq)));
  assign w_bubble = s.flush | w_stall | ~r_valid;
  always_comb begin
    w_dec          = '0;
    w_dec.valid    = 1'b1;
    w_dec.regwrite = w_r | w_lw | w_addi | w_ori | w_lui;
    w_dec.memread  = w_lw;
    w_dec.memwrite = w_sw;
    w_dec.memtoreg = w_lw;
    w_dec.alusrc   = w_lw | w_sw | w_addi | w_ori | w_lui;
    w_dec.regdst   = w_r;
    w_dec.aluop    = w_r ? 2'b10 : w_beq ? 2'b01 : w_ori ? 2'b11 : 2'b00;
    w_dec.rs       = r_ir[25:21];
    w_dec.rt       = r_ir[20:16];
    w_dec.rd       = r_ir[15:11];
    w_dec.imm32    = w_ori ? {16'h0000, w_imm} : w_lui ? {w_imm, 16'h0000} : {{16{w_imm[15]}}, w_imm};
    w_dec.funct    = r_ir[5:0];
    w_dec.illegal  = ~w_known;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir    <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (s.flush) begin
      r_ir    <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ir    <= s.if_ir;
      r_valid <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ex <= '0;
    else r_ex <= w_bubble ? '0 : w_dec;
  end
  assign s.stall       = w_stall;
  assign s.if_branch   = w_beq & r_valid & ~w_stall & ~s.flush;
  assign s.if_jump     = w_j & r_valid & ~w_stall & ~s.flush;
  assign s.if_imm16    = r_ir[15:0];
  assign s.if_imm26    = r_ir[25:0];
  assign s.ex_valid    = r_ex.valid;
  assign s.ex_regwrite = r_ex.regwrite;
  assign s.ex_memread  = r_ex.memread;
  assign s.ex_memwrite = r_ex.memwrite;
  assign s.ex_memtoreg = r_ex.memtoreg;
  assign s.ex_alusrc   = r_ex.alusrc;
  assign s.ex_regdst   = r_ex.regdst;
  assign s.ex_aluop    = r_ex.aluop;
  assign s.ex_rs       = r_ex.rs;
  assign s.ex_rt       = r_ex.rt;
  assign s.ex_rd       = r_ex.rd;
  assign s.ex_imm32    = r_ex.imm32;
  assign s.ex_funct    = r_ex.funct;
  assign s.illegal     = r_ex.illegal;
endmodule
